// File: rtl/button_pkg.sv
// Shared push-button definitions: debounce FSM state encoding and default timing.
package button_pkg;

  // 10 ms of stable samples at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } debounce_state_t;

endpackage

// File: rtl/debounce_fsm.sv
// Push-button debouncer: accepts a level change only after DEBOUNCE_CYCLES consecutive
// equal samples of the synchronized input. Produces a registered clean level, one-cycle
// press/release pulses and a wrapping count of accepted presses.
module debounce_fsm
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int PRESS_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_sync,
  output logic               btn_level,
  output logic               btn_press,
  output logic               btn_release,
  output logic [PRESS_W-1:0] press_count
);

  // Stability counter width follows from the debounce length; not meant to be overridden.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  debounce_state_t     state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                level_nxt;
  logic                press_nxt;
  logic                release_nxt;
  logic [PRESS_W-1:0]  count_nxt;

  // Next-state and next-output decode; pulses default low so they last one cycle only.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    count_nxt   = press_count;
    case (state)
      S_LOW: begin
        if (in_sync) begin
          state_nxt = S_WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!in_sync) begin
          // Bounce: drop back without touching the outputs
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          count_nxt = press_count + PRESS_W'(1);
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!in_sync) begin
          state_nxt = S_WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (in_sync) begin
          state_nxt   = S_HIGH;
          cnt_nxt     = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = S_LOW;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and all outputs registered; reset clears everything without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LOW;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      press_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm with DEBOUNCE_CYCLES=4, PRESS_W=3.
module tb_debounce_fsm;
  import button_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_sync;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic [2:0] press_count;

  int errors = 0;
  int checks = 0;

  debounce_fsm #(.DEBOUNCE_CYCLES(4), .PRESS_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_sync     (in_sync),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       in_v;
    logic       lvl;
    logic       prs;
    logic       rel;
    logic [2:0] cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic in_v, input logic lvl, input logic prs,
                              input logic rel, input logic [2:0] cnt, input string name);
    vec_t v;
    v.in_v = in_v; v.lvl = lvl; v.prs = prs; v.rel = rel; v.cnt = cnt; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic lvl, input logic prs,
                         input logic rel, input logic [2:0] cnt);
    chk({name, ".level"},   {31'd0, btn_level},   {31'd0, lvl});
    chk({name, ".press"},   {31'd0, btn_press},   {31'd0, prs});
    chk({name, ".release"}, {31'd0, btn_release}, {31'd0, rel});
    chk({name, ".count"},   {29'd0, press_count}, {29'd0, cnt});
  endtask

  // Drive one sample; it is taken at the next rising edge, outputs checked 1 time unit later.
  task automatic step(input logic v);
    in_sync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    in_sync = v;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset.state", {30'd0, dut.state}, {30'd0, S_LOW});
    rst = 1'b0;
  endtask

  // Protocol monitor: pulses exclusive and never on two consecutive cycles.
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (btn_press && btn_release) begin
        errors++;
        $display("FAIL pulse_exclusive: press=%0b release=%0b required not both 1", btn_press, btn_release);
      end
      if (prev_pulse && (btn_press || btn_release)) begin
        errors++;
        $display("FAIL back_to_back: pulse high on consecutive cycles, required single cycle");
      end
      prev_pulse = btn_press | btn_release;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    logic [2:0] exp_cnt;
    rst = 1'b1;
    in_sync = 1'b0;

    // Test 1: reset and idle low
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if (i % 5 == 4) chk_out("idle", 1'b0, 1'b0, 1'b0, 3'd0);
    end

    // Tests 2-4 as a vector table
    add(1, 0, 0, 0, 3'd0, "press_e1");
    add(1, 0, 0, 0, 3'd0, "press_e2");
    add(1, 0, 0, 0, 3'd0, "press_e3");
    add(1, 1, 1, 0, 3'd1, "press_e4");
    add(1, 1, 0, 0, 3'd1, "press_after");
    add(0, 1, 0, 0, 3'd1, "hglitch_e1");
    add(0, 1, 0, 0, 3'd1, "hglitch_e2");
    add(0, 1, 0, 0, 3'd1, "hglitch_e3");
    add(1, 1, 0, 0, 3'd1, "hglitch_back");
    add(0, 1, 0, 0, 3'd1, "rel_e1");
    add(0, 1, 0, 0, 3'd1, "rel_e2");
    add(0, 1, 0, 0, 3'd1, "rel_e3");
    add(0, 0, 0, 1, 3'd1, "rel_e4");
    add(0, 0, 0, 0, 3'd1, "rel_after");
    add(1, 0, 0, 0, 3'd1, "bounce_e1");
    add(1, 0, 0, 0, 3'd1, "bounce_e2");
    add(1, 0, 0, 0, 3'd1, "bounce_e3");
    add(0, 0, 0, 0, 3'd1, "bounce_low1");
    add(0, 0, 0, 0, 3'd1, "bounce_low2");
    foreach (vecs[i]) begin
      step(vecs[i].in_v);
      chk_out(vecs[i].name, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].cnt);
    end

    // Test 5: nine clean press/release cycles from reset, count wraps at 3 bits
    do_reset(1'b0);
    exp_cnt = 3'd0;
    for (int k = 0; k < 9; k++) begin
      exp_cnt = exp_cnt + 3'd1;
      repeat (3) step(1'b1);
      step(1'b1);
      chk_out("wrap_press", 1'b1, 1'b1, 1'b0, exp_cnt);
      repeat (3) step(1'b0);
      step(1'b0);
      chk_out("wrap_release", 1'b0, 1'b0, 1'b1, exp_cnt);
    end
    chk("wrap_final", {29'd0, press_count}, 32'd1);

    // Test 6a: reset in the middle of a press pulse
    do_reset(1'b0);
    repeat (3) step(1'b1);
    step(1'b1);
    chk_out("midpulse_pre", 1'b1, 1'b1, 1'b0, 3'd1);
    rst = 1'b1;
    #1;
    chk_out("midpulse_rst", 1'b0, 1'b0, 1'b0, 3'd0);
    chk("midpulse_rst.state", {30'd0, dut.state}, {30'd0, S_LOW});

    // Test 6b: reset during S_WAIT_HIGH with cnt=2, input held high
    do_reset(1'b1);
    step(1'b1);
    step(1'b1);
    chk("midwait.state", {30'd0, dut.state}, {30'd0, S_WAIT_HIGH});
    chk("midwait.cnt", {30'd0, dut.cnt}, 32'd2);
    rst = 1'b1;
    #1;
    chk_out("midwait_rst", 1'b0, 1'b0, 1'b0, 3'd0);
    chk("midwait_rst.cnt", {30'd0, dut.cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1);
    chk_out("after_rst_e1", 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1);
    step(1'b1);
    chk_out("after_rst_e3", 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1);
    chk_out("after_rst_e4", 1'b1, 1'b1, 1'b0, 3'd1);
    step(1'b1);
    chk_out("after_rst_e5", 1'b1, 1'b0, 1'b0, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
